// File: rtl/ddr_axi_traffic_gen.sv
// AXI write/read-back traffic generator: writes NUM_BURSTS bursts of a counting pattern,
// reads them back, and reports mismatches, rlast errors and handshake timeouts.
module ddr_axi_traffic_gen #(
  parameter int unsigned BA_BITS    = 2,
  parameter int unsigned ROW_BITS   = 13,
  parameter int unsigned COL_BITS   = 11,
  parameter int unsigned DQ_LEVEL   = 1,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned NUM_BURSTS = 4,
  parameter logic [15:0] SEED       = 16'hA5C3,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned DW = 8 << DQ_LEVEL,
  localparam int unsigned AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_sync,
  input  logic          start,
  output logic          awvalid,
  input  logic          awready,
  output logic [AW-1:0] awaddr,
  output logic [7:0]    awlen,
  output logic          wvalid,
  input  logic          wready,
  output logic          wlast,
  output logic [DW-1:0] wdata,
  input  logic          bvalid,
  output logic          bready,
  output logic          arvalid,
  input  logic          arready,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  input  logic          rvalid,
  output logic          rready,
  input  logic          rlast,
  input  logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_cnt
);

  localparam int unsigned PW = (DW > 32) ? DW : 32;

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

  state_e        state_q, state_d;
  logic [15:0]   burst_q;
  logic [7:0]    beat_q;
  logic [15:0]   wd_q;
  logic [15:0]   err_q, err_d;
  logic          to_q;
  logic          to_hit;

  logic          active, last_beat, last_burst;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0]   n_idx;
  logic [PW-1:0] pat_full;
  logic [DW-1:0] pattern;
  logic [AW-1:0] burst_addr;
  logic [16:0]   err_sum;
  logic [1:0]    err_inc;

  assign active     = (state_q != StIdle) && (state_q != StDone);
  assign last_beat  = (beat_q == 8'(BURST_LEN - 1));
  assign last_burst = (burst_q == 16'(NUM_BURSTS - 1));

  // Valids/readies are pure state decodes, so a handshake is state plus the slave's signal.
  assign aw_hs = (state_q == StAw) && awready;
  assign w_hs  = (state_q == StW) && wready;
  assign b_hs  = (state_q == StB) && bvalid;
  assign ar_hs = (state_q == StAr) && arready;
  assign r_hs  = (state_q == StR) && rvalid;

  assign n_idx      = 32'(burst_q) * BURST_LEN + 32'(beat_q);
  assign pat_full   = PW'(SEED) + PW'(n_idx) * PW'(32'h0101);
  assign pattern    = pat_full[DW-1:0];
  assign burst_addr = AW'(32'(burst_q) * BURST_LEN);

  assign err_inc = {1'b0, (rdata != pattern)} + {1'b0, (rlast != last_beat)};
  assign err_sum = {1'b0, err_q} + {15'd0, err_inc};
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst_sync) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    to_hit  = 1'b0;
    case (state_q)
      StIdle, StDone: if (start) state_d = StAw;
      StAw:           if (awready) state_d = StW;
      StW:            if (wready && last_beat) state_d = StB;
      StB:            if (bvalid) state_d = last_burst ? StAr : StAw;
      StAr:           if (arready) state_d = StR;
      StR:            if (rvalid && last_beat) state_d = last_burst ? StDone : StAr;
      default:        state_d = StIdle;
    endcase
    // Watchdog only fires on a cycle with no handshake at all.
    if (active && !(aw_hs || w_hs || b_hs || ar_hs || r_hs) && (wd_q >= 16'(TIMEOUT - 1))) begin
      state_d = StDone;
      to_hit  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_sync) begin
      burst_q <= '0;
      beat_q  <= '0;
      wd_q    <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      if (!active && start) begin
        burst_q <= '0;
        err_q   <= '0;
        to_q    <= 1'b0;
      end
      if (aw_hs || ar_hs) beat_q <= '0;
      if (w_hs || r_hs) beat_q <= beat_q + 8'd1;
      if (b_hs) burst_q <= last_burst ? 16'd0 : burst_q + 16'd1;
      if (r_hs && last_beat) burst_q <= burst_q + 16'd1;
      if (r_hs) err_q <= err_d;
      if (to_hit) to_q <= 1'b1;
      if ((state_d != state_q) || w_hs || r_hs) begin
        wd_q <= '0;
      end else if (active) begin
        wd_q <= wd_q + 16'd1;
      end
    end
  end

  always_comb begin
    awvalid = (state_q == StAw);
    awaddr  = awvalid ? burst_addr : '0;
    awlen   = awvalid ? 8'(BURST_LEN - 1) : 8'd0;
    wvalid  = (state_q == StW);
    wdata   = wvalid ? pattern : '0;
    wlast   = wvalid && last_beat;
    bready  = (state_q == StB);
    arvalid = (state_q == StAr);
    araddr  = arvalid ? burst_addr : '0;
    arlen   = arvalid ? 8'(BURST_LEN - 1) : 8'd0;
    rready  = (state_q == StR);
    busy    = active;
    done    = (state_q == StDone);
    pass    = done && (err_q == 16'd0) && !to_q;
    timeout = to_q;
    err_cnt = err_q;
  end

endmodule

// File: tb/tb_ddr_axi_traffic_gen.sv
// Bench for ddr_axi_traffic_gen: memory-backed AXI slave model with optional stalls and
// injected read faults, driven from a table of scenarios plus a mid-burst reset sequence.
module tb_ddr_axi_traffic_gen;

  localparam int BL  = 8;
  localparam int NB  = 4;
  localparam int TMO = 1024;

  logic        sys_clk, sys_rst_sync, start;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [25:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [15:0] wdata, rdata, err_cnt;
  logic        busy, done, pass, timeout;

  ddr_axi_traffic_gen dut (
    .sys_clk(sys_clk), .sys_rst_sync(sys_rst_sync), .start(start),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    string name;
    bit    stall;
    bit    no_b;
    int    cor_burst;
    int    cor_beat;
    int    rl_burst;
    int    rl_beat;
    bit    poke;
    bit    exp_pass;
    bit    exp_to;
    int    exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } rbeat_t;

  int n_chk = 0;
  int n_pass = 0;

  // Scenario knobs and slave/model state
  bit  stall = 0, no_b = 0;
  int  cor_burst = -1, cor_beat = -1, rl_burst = -1, rl_beat = -1;
  int  aw_cnt, w_n, ar_cnt, r_cnt, pend_b, bready_cycles;
  logic [15:0] mem [int];
  rbeat_t rq[$];

  function automatic logic [15:0] pat(int unsigned n);
    return 16'(32'hA5C3 + n * 32'h0101);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic reset_model();
    aw_cnt = 0; w_n = 0; ar_cnt = 0; r_cnt = 0; pend_b = 0; bready_cycles = 0;
    mem.delete();
    rq.delete();
  endtask

  function automatic vec_t mk(string name, bit st, bit nb, int cb, int cbt, int rb, int rbt,
                              bit pk, bit ep, bit et, int ee);
    vec_t v;
    v.name = name; v.stall = st; v.no_b = nb; v.cor_burst = cb; v.cor_beat = cbt;
    v.rl_burst = rb; v.rl_beat = rbt; v.poke = pk; v.exp_pass = ep; v.exp_to = et;
    v.exp_err = ee;
    return v;
  endfunction

  // Slave: updates its drives at each negedge, then accounts for the handshakes that the
  // coming posedge will complete (DUT outputs are stable between posedges).
  initial begin : slave
    logic        prev_aw_wait, prev_w_wait, prev_ar_wait, prev_wlast;
    logic [25:0] prev_awaddr, prev_araddr;
    logic [15:0] prev_wdata;
    rbeat_t      rb;
    int          a;
    prev_aw_wait = 0; prev_w_wait = 0; prev_ar_wait = 0;
    prev_awaddr = '0; prev_araddr = '0; prev_wdata = '0; prev_wlast = 0;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_sync) begin
        prev_aw_wait = 0; prev_w_wait = 0; prev_ar_wait = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0; rdata = '0;
        continue;
      end
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = !no_b && (pend_b > 0);
      if (rq.size() > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
        rvalid = 1'b1; rdata = rq[0].d; rlast = rq[0].l;
      end else begin
        rvalid = 1'b0; rdata = '0; rlast = 1'b0;
      end
      if (bready) bready_cycles++;

      if (prev_aw_wait) chk("awaddr_stable", 32'({awvalid, awaddr}), 32'({1'b1, prev_awaddr}));
      if (prev_w_wait)
        chk("wdata_stable", 32'({wvalid, wlast, wdata}), 32'({1'b1, prev_wlast, prev_wdata}));
      if (prev_ar_wait) chk("araddr_stable", 32'({arvalid, araddr}), 32'({1'b1, prev_araddr}));
      prev_aw_wait = awvalid && !awready; prev_awaddr = awaddr;
      prev_w_wait  = wvalid && !wready;   prev_wdata = wdata; prev_wlast = wlast;
      prev_ar_wait = arvalid && !arready; prev_araddr = araddr;

      if (awvalid && awready) begin
        chk("awaddr", 32'(awaddr), 32'(aw_cnt * BL));
        chk("awlen", 32'(awlen), 32'(BL - 1));
        aw_cnt++;
      end
      if (wvalid && wready) begin
        chk("wdata", 32'(wdata), 32'(pat(w_n)));
        chk("wlast", 32'(wlast), 32'((w_n % BL) == BL - 1));
        mem[w_n] = wdata;
        if ((w_n % BL) == BL - 1) pend_b++;
        w_n++;
      end
      if (bvalid && bready) pend_b--;
      if (arvalid && arready) begin
        chk("araddr", 32'(araddr), 32'(ar_cnt * BL));
        chk("arlen", 32'(arlen), 32'(BL - 1));
        for (int i = 0; i < BL; i++) begin
          a = ar_cnt * BL + i;
          rb.d = mem.exists(a) ? mem[a] : 16'hDEAD;
          if (ar_cnt == cor_burst && i == cor_beat) rb.d = rb.d ^ 16'h0001;
          rb.l = (ar_cnt == rl_burst) ? (i == rl_beat) : (i == BL - 1);
          rq.push_back(rb);
        end
        ar_cnt++;
      end
      if (rvalid && rready) begin
        void'(rq.pop_front());
        r_cnt++;
      end
    end
  end

  task automatic check_reset_outputs();
    chk("reset_outputs_zero",
        32'(|{awvalid, awaddr, awlen, wvalid, wlast, wdata, bready, arvalid, araddr, arlen,
              rready, busy, done, pass, timeout, err_cnt}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int cyc;
    reset_model();
    stall = v.stall; no_b = v.no_b;
    cor_burst = v.cor_burst; cor_beat = v.cor_beat;
    rl_burst = v.rl_burst; rl_beat = v.rl_beat;
    pulse_start();
    chk({v.name, "_busy_after_start"}, 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(negedge sys_clk);
      cyc++;
      if (v.poke && cyc == 20) begin
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk({v.name, "_done"}, 32'(done), 32'd1);
    chk({v.name, "_pass"}, 32'(pass), 32'(v.exp_pass));
    chk({v.name, "_timeout"}, 32'(timeout), 32'(v.exp_to));
    chk({v.name, "_err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
    chk({v.name, "_busy_end"}, 32'(busy), 32'd0);
    if (!v.no_b) begin
      chk({v.name, "_aw_count"}, 32'(aw_cnt), 32'(NB));
      chk({v.name, "_w_count"}, 32'(w_n), 32'(NB * BL));
      chk({v.name, "_ar_count"}, 32'(ar_cnt), 32'(NB));
      chk({v.name, "_r_count"}, 32'(r_cnt), 32'(NB * BL));
    end else begin
      chk({v.name, "_b_wait_cycles"}, 32'(bready_cycles), 32'(TMO));
      chk({v.name, "_bready_low"}, 32'(bready), 32'd0);
    end
    repeat (3) @(negedge sys_clk);
    chk({v.name, "_done_held"}, 32'(done), 32'd1);
  endtask

  initial begin : main
    vec_t vecs[5];
    int   cyc;
    vecs[0] = mk("ideal",       0, 0, -1, -1, -1, -1, 0, 1, 0, 0);
    vecs[1] = mk("stall",       1, 0, -1, -1, -1, -1, 1, 1, 0, 0);
    vecs[2] = mk("corrupt",     1, 0,  1,  3, -1, -1, 0, 0, 0, 1);
    vecs[3] = mk("early_rlast", 0, 0, -1, -1,  0,  5, 0, 0, 0, 2);
    vecs[4] = mk("no_bvalid",   0, 1, -1, -1, -1, -1, 0, 0, 1, 0);

    sys_rst_sync = 1'b1;
    start = 1'b0;
    reset_model();
    repeat (3) @(negedge sys_clk);
    check_reset_outputs();
    sys_rst_sync = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of burst 2's write data, then a fresh pass from address 0.
    reset_model();
    stall = 0; no_b = 0; cor_burst = -1; cor_beat = -1; rl_burst = -1; rl_beat = -1;
    pulse_start();
    cyc = 0;
    while (!(aw_cnt == 3 && wvalid === 1'b1) && cyc < 2000) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("reached_w_burst2", 32'(wvalid), 32'd1);
    sys_rst_sync = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_reset_outputs();
    sys_rst_sync = 1'b0;
    run_vec(mk("after_reset", 0, 0, -1, -1, -1, -1, 1, 1, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_axi_traffic_gen.md
Name: ddr_axi_traffic_gen

Overview:
- AXI-side initiator that drives the DDR controller's slave interface: write address, write data, write response, read address and read data channels.
- Writes NUM_BURSTS bursts of a deterministic data pattern, then reads the same bursts back and compares each beat.
- Reports pass/fail, a mismatch count and a timeout flag.
- Sits outside the controller top, used for bring-up on board and as the bench stimulus master.

Parameters:
- BA_BITS, 2, bank address bits.
- ROW_BITS, 13, row address bits.
- COL_BITS, 11, column address bits.
- DQ_LEVEL, 1, data width selector; AXI data width DW = 8<<DQ_LEVEL.
- BURST_LEN, 8, beats per burst (1..256); awlen = arlen = BURST_LEN-1.
- NUM_BURSTS, 4, bursts per pass (1..65535).
- SEED, 16'hA5C3, pattern base value, truncated or zero-extended to DW.
- TIMEOUT, 1024, max cycles waiting on any single handshake.

Ports:
- sys_clk  in  1  clock, the same clock as the controller's AXI side.
- sys_rst_sync  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a pass from IDLE or DONE.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- awaddr  out  AW = BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-1  burst start address, in beat units.
- awlen  out  8  write burst length minus 1.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- wlast  out  1  last write beat.
- wdata  out  DW  write data.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- araddr  out  AW  read burst start address.
- arlen  out  8  read burst length minus 1.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- rlast  in  1  last read beat.
- rdata  in  DW  read data.
- busy  out  1  pass in progress.
- done  out  1  pass finished; held until the next start or reset.
- pass  out  1  valid when done: err_cnt==0 and no timeout.
- timeout  out  1  a handshake waited longer than TIMEOUT cycles.
- err_cnt  out  16  beat mismatches plus rlast protocol errors, saturating at 16'hFFFF.

Behaviour:
Reset:
- sys_rst_sync=1 at a clock edge forces state IDLE and clears all counters.
- Every output goes to 0: all valids, bready, rready, wlast, addresses, data, busy, done, pass, timeout, err_cnt.
- Reset asserted mid-burst abandons the burst immediately; no cleanup beats are sent.

State machine (IDLE, AW, W, B, AR, R, DONE):
- IDLE/DONE: start=1 -> AW. On that edge clear done, pass, timeout, err_cnt and burst_idx. start in any other state is ignored.
- AW: awvalid=1, awaddr = burst_idx*BURST_LEN mod 2^AW, awlen = BURST_LEN-1. awvalid and awaddr stay stable until awready. On awvalid&awready -> W with beat_idx=0.
- W: wvalid=1, wdata = pattern(burst_idx*BURST_LEN + beat_idx), wlast = (beat_idx==BURST_LEN-1).
  - A beat advances only on wvalid&wready; wdata and wlast hold otherwise.
  - Last beat accepted -> B.
- B: bready=1. On bvalid:
  - if burst_idx==NUM_BURSTS-1 -> AR with burst_idx=0;
  - else burst_idx+1 -> AW.
- AR: same rules as AW, on the ar* signals -> R.
- R: rready=1. Each rvalid&rready beat compares rdata with pattern(burst_idx*BURST_LEN + beat_idx) and is an error if they differ.
  - Also an error: rlast != (beat_idx==BURST_LEN-1). A data mismatch and an rlast error on the same beat count as 2.
  - The burst ends on the beat where beat_idx==BURST_LEN-1, regardless of rlast.
  - Then burst_idx+1 -> AR, or -> DONE after the last burst.
- DONE: done=1; pass = (err_cnt==0)&&!timeout; busy=0.

Pattern:
- pattern(n) = (SEED + n*16'h0101) truncated to DW. The index n is 32-bit and wraps modulo 2^32.

Valid timing:
- Valids are registered and assert the cycle after entering a state.
- They deassert in the same cycle the handshake completes, except a W beat that is not last.
- No combinational path from any ready to any valid.
- Back-to-back W beats: when wready is held high, one beat per cycle.

Watchdog:
- A 16-bit counter clears on every state change and on every W/R handshake, and increments otherwise in AW/W/B/AR/R.
- Reaching TIMEOUT sets timeout=1, drops all valids and readies, and goes -> DONE.

Counters:
- err_cnt saturates at 16'hFFFF and never wraps.

Test Plan:
- Default params, ideal slave (ready=1, zero-latency B, R returns written data) -> 4 AW at addrs 0,8,16,24 with awlen=7; 32 W beats, first wdata=16'hA5C3, second 16'hA6C4; wlast on beats 7,15,23,31; done=1, pass=1, err_cnt=0.
- Slave toggles wready/awready/arready pseudo-randomly -> awaddr/wdata/wlast stable while stalled; same result as the ideal slave; no beat duplicated or skipped.
- Slave corrupts rdata on read beat 3 of burst 1 -> err_cnt=1, pass=0, done=1.
- Slave asserts rlast on beat 5 of burst 0 -> err_cnt=2 (early rlast plus missing rlast on beat 7), pass=0.
- Slave never asserts bvalid -> TIMEOUT=1024 cycles after entering B: timeout=1, done=1, pass=0, bready=0.
- sys_rst_sync pulsed during W burst 2, then start -> all outputs 0 after reset; new pass begins at awaddr=0 with wdata=SEED; start pulsed while busy has no effect.
